// File: rtl/bru_scheduler.sv
// bru_scheduler: in-order branch issue queue with flag wait, resolution register and wrong-path squash.
package bru_pkg;
  typedef enum logic [1:0] {UOP_NOP, UOP_BL, UOP_BCOND, UOP_ALU} uop_e;
  typedef struct packed {
    logic        valid;
    uop_e        uopcode;
    logic [3:0]  cond;
    logic [63:0] r2_val;
  } rob_issue;
  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } RegFileWritePort;
endpackage

module bru_scheduler
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enq_valid_in,
  output logic             enq_ready_out,
  input  rob_issue         enq_insn_in,
  input  logic [63:0]      enq_pc_in,
  input  logic [TAG_W-1:0] enq_tag_in,
  input  logic             enq_pred_taken_in,
  input  logic [63:0]      enq_pred_target_in,
  input  logic             flags_valid_in,
  input  logic [3:0]       flags_in,
  output rob_issue         dec_insn_out,
  output logic [63:0]      dec_pc_out,
  output logic [3:0]       dec_flags_out,
  input  logic             dec_taken_in,
  input  logic [63:0]      dec_target_in,
  input  RegFileWritePort  dec_reg_pkt_in,
  output RegFileWritePort  reg_pkt_out,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [TAG_W-1:0] res_tag_out,
  output logic             res_taken_out,
  output logic             res_mispredict_out,
  output logic [63:0]      res_next_pc_out,
  input  logic             flush_in
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    rob_issue         insn;
    logic [63:0]      pc;
    logic [TAG_W-1:0] tag;
    logic             pred_taken;
    logic [63:0]      pred_target;
  } entry_t;
  typedef enum logic {RUN, SQUASH} state_e;
  entry_t        mem [DEPTH];
  entry_t        hd;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  state_e        state, state_nx;
  logic          kill, eligible, issue, taken, mispredict, squash, enq_fire;
  assign hd = mem[head];
  assign kill = rst_in || flush_in;
  always_comb begin
    eligible = count != '0 && (hd.insn.uopcode != UOP_BCOND || flags_valid_in);
    issue = eligible && state == RUN && !kill && (!res_valid_out || res_ready_in);
    // only real branch uops may redirect; anything else resolves not-taken
    taken = (hd.insn.uopcode == UOP_BL || hd.insn.uopcode == UOP_BCOND) ? dec_taken_in : 1'b0;
    mispredict = (taken != hd.pred_taken) || (taken && dec_target_in != hd.pred_target);
    squash = issue && mispredict;
    enq_fire = enq_valid_in && enq_ready_out;
  end
  always_ff @(posedge clk_in)
    state <= kill ? RUN : state_nx;
  always_comb
    state_nx = state == RUN ? (squash ? SQUASH : RUN) : (res_valid_out && res_ready_in ? RUN : SQUASH);
  always_comb begin
    enq_ready_out = count < CW'(DEPTH) && state == RUN && !kill;
    dec_insn_out = hd.insn;
    dec_insn_out.valid = issue;
    dec_pc_out = hd.pc;
    dec_flags_out = flags_in;
    reg_pkt_out = issue ? dec_reg_pkt_in : '0;
  end
  always_ff @(posedge clk_in) begin
    if (kill) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      res_valid_out <= 1'b0;
      res_tag_out <= '0;
      res_taken_out <= 1'b0;
      res_mispredict_out <= 1'b0;
      res_next_pc_out <= '0;
    end else begin
      if (enq_fire && !squash) begin
        mem[tail] <= '{insn: enq_insn_in, pc: enq_pc_in, tag: enq_tag_in,
                       pred_taken: enq_pred_taken_in, pred_target: enq_pred_target_in};
        tail <= tail + PW'(1);
      end
      // a squash empties the queue by snapping head onto the unchanged tail
      head <= squash ? tail : head + PW'(issue);
      count <= squash ? '0 : count + CW'(enq_fire) - CW'(issue);
      if (issue) begin
        res_valid_out <= 1'b1;
        res_tag_out <= hd.tag;
        res_taken_out <= taken;
        res_mispredict_out <= mispredict;
        res_next_pc_out <= taken ? dec_target_in : hd.pc + 64'd4;
      end else if (res_ready_in) begin
        res_valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bru_scheduler.sv
// tb_bru_scheduler: directed checks of bru_scheduler with a behavioural branch decoder in the loop.
module tb_bru_scheduler;
  import bru_pkg::*;
  logic            clk = 0;
  logic            rst, enq_valid, enq_ready, flags_valid, res_ready, res_valid, flush;
  logic            dec_taken, res_taken, res_misp, enq_pt;
  rob_issue        enq_insn, dec_insn;
  logic [63:0]     enq_pc, enq_ptgt, dec_pc, dec_target, res_next_pc;
  logic [5:0]      enq_tag, res_tag;
  logic [3:0]      flags, dec_flags;
  RegFileWritePort dec_pkt, reg_pkt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  bru_scheduler #(.DEPTH(4), .TAG_W(6)) dut (
    .clk_in(clk), .rst_in(rst), .enq_valid_in(enq_valid), .enq_ready_out(enq_ready),
    .enq_insn_in(enq_insn), .enq_pc_in(enq_pc), .enq_tag_in(enq_tag),
    .enq_pred_taken_in(enq_pt), .enq_pred_target_in(enq_ptgt),
    .flags_valid_in(flags_valid), .flags_in(flags), .dec_insn_out(dec_insn),
    .dec_pc_out(dec_pc), .dec_flags_out(dec_flags), .dec_taken_in(dec_taken),
    .dec_target_in(dec_target), .dec_reg_pkt_in(dec_pkt), .reg_pkt_out(reg_pkt),
    .res_valid_out(res_valid), .res_ready_in(res_ready), .res_tag_out(res_tag),
    .res_taken_out(res_taken), .res_mispredict_out(res_misp),
    .res_next_pc_out(res_next_pc), .flush_in(flush)
  );

  // decoder stand-in: word offset in r2_val, EQ/NE on Z, BL links to x30
  always_comb begin
    dec_taken = 1'b0;
    dec_target = dec_pc + (dec_insn.r2_val << 2);
    dec_pkt = '0;
    if (dec_insn.uopcode == UOP_BL) begin
      dec_taken = 1'b1;
      dec_pkt = '{en: 1'b1, addr: 5'd30, data: dec_pc + 64'd4};
    end else if (dec_insn.uopcode == UOP_BCOND)
      dec_taken = dec_insn.cond == 4'd0 ? dec_flags[2] : dec_insn.cond == 4'd1 ? !dec_flags[2] : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input uop_e op, input logic [3:0] c, input logic [63:0] r2, input logic [63:0] pc,
                       input logic [5:0] tag, input logic pt, input logic [63:0] ptgt);
    enq_valid = 1'b1;
    enq_insn = '{valid: 1'b1, uopcode: op, cond: c, r2_val: r2};
    enq_pc = pc;
    enq_tag = tag;
    enq_pt = pt;
    enq_ptgt = ptgt;
  endtask

  initial begin
    rst = 1; flush = 0; enq_valid = 0; enq_insn = '0; enq_pc = 0; enq_tag = 0; enq_pt = 0;
    enq_ptgt = 0; flags_valid = 1; flags = 4'b0000; res_ready = 1;
    tick; tick;
    chk("ready_in_reset", enq_ready, 0);
    rst = 0;
    tick;
    chk("rst_ready", enq_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_dec_valid", dec_insn.valid, 0);
    chk("rst_reg_en", reg_pkt.en, 0);

    // single correctly predicted BL
    offer(UOP_BL, 4'd0, 64'd4, 64'h1000, 6'd1, 1'b1, 64'h1010);
    tick;
    enq_valid = 0;
    #1;
    chk("bl_issue", dec_insn.valid, 1);
    chk("bl_link_en", reg_pkt.en, 1);
    chk("bl_link_data", reg_pkt.data, 64'h1004);
    tick;
    chk("bl_res_valid", res_valid, 1);
    chk("bl_tag", res_tag, 1);
    chk("bl_taken", res_taken, 1);
    chk("bl_next_pc", res_next_pc, 64'h1010);
    chk("bl_misp", res_misp, 0);
    chk("bl_link_gone", reg_pkt.en, 0);
    tick;
    chk("bl_res_drained", res_valid, 0);

    // B.cond NE with Z=1, predicted not taken
    flags = 4'b0100;
    offer(UOP_BCOND, 4'd1, 64'd8, 64'h3000, 6'd2, 1'b0, 64'h0);
    tick;
    enq_valid = 0;
    #1;
    chk("ne_issue", dec_insn.valid, 1);
    chk("ne_no_link", reg_pkt.en, 0);
    tick;
    chk("ne_tag", res_tag, 2);
    chk("ne_taken", res_taken, 0);
    chk("ne_next_pc", res_next_pc, 64'h3004);
    chk("ne_misp", res_misp, 0);
    tick;

    // B.cond EQ waits on flags, then mispredicts and squashes younger entries
    flags_valid = 0;
    offer(UOP_BCOND, 4'd0, 64'd8, 64'h2000, 6'd3, 1'b0, 64'h0);
    tick;
    offer(UOP_BL, 4'd0, 64'd1, 64'h2100, 6'd4, 1'b1, 64'h2104);
    #1 chk("eq_wait1", dec_insn.valid, 0);
    tick;
    offer(UOP_BL, 4'd0, 64'd1, 64'h2200, 6'd5, 1'b1, 64'h2204);
    #1 chk("eq_wait2", dec_insn.valid, 0);
    tick;
    enq_valid = 0;
    #1 chk("eq_wait3", dec_insn.valid, 0);
    tick;
    flags_valid = 1; flags = 4'b0100; res_ready = 0;
    offer(UOP_BL, 4'd0, 64'd1, 64'h2300, 6'd6, 1'b1, 64'h2304);
    #1;
    chk("eq_issue", dec_insn.valid, 1);
    chk("eq_ready_before", enq_ready, 1);
    tick;
    enq_valid = 0;
    #1;
    chk("eq_res_valid", res_valid, 1);
    chk("eq_tag", res_tag, 3);
    chk("eq_misp", res_misp, 1);
    chk("eq_next_pc", res_next_pc, 64'h2020);
    chk("sq_ready", enq_ready, 0);
    tick;
    chk("sq_held", res_valid, 1);
    chk("sq_ready_held", enq_ready, 0);
    res_ready = 1;
    #1 chk("sq_ready_hs", enq_ready, 0);
    tick;
    chk("sq_res_done", res_valid, 0);
    chk("sq_ready_back", enq_ready, 1);
    chk("sq_discarded", dec_insn.valid, 0);
    tick;
    chk("sq_discarded2", res_valid, 0);

    // fill to full while the result is held, then drain in order with a refill
    res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      offer(UOP_BL, 4'd0, 64'd1, 64'h4000 + 64'(i) * 64'h10, 6'(8 + i), 1'b1, 64'h4004 + 64'(i) * 64'h10);
      tick;
    end
    enq_valid = 0;
    #1;
    chk("full_ready", enq_ready, 0);
    chk("full_stall", dec_insn.valid, 0);
    chk("full_held_tag", res_tag, 8);
    res_ready = 1;
    #1 chk("bypass_issue", dec_insn.valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 0) begin
        chk("full_ready_back", enq_ready, 1);
        offer(UOP_BL, 4'd0, 64'd1, 64'h4050, 6'd13, 1'b1, 64'h4054);
      end else enq_valid = 0;
      #1;
      chk("drain_valid", res_valid, 1);
      chk("drain_tag", res_tag, 64'(9 + i));
      chk("drain_pc", res_next_pc, 64'h4014 + 64'(i) * 64'h10);
      chk("drain_misp", res_misp, 0);
    end
    tick;
    chk("drain_empty", res_valid, 0);

    // flush with three queued entries, a held result and a simultaneous enqueue
    res_ready = 0;
    for (int i = 0; i < 4; i++) begin
      offer(UOP_BL, 4'd0, 64'd1, 64'h5000 + 64'(i) * 64'h10, 6'(20 + i), 1'b1, 64'h5004 + 64'(i) * 64'h10);
      tick;
    end
    enq_valid = 0;
    #1;
    chk("pre_flush_held", res_tag, 20);
    chk("held_link_gated", reg_pkt.en, 0);
    offer(UOP_BL, 4'd0, 64'd1, 64'h5040, 6'd24, 1'b1, 64'h5044);
    flush = 1;
    #1;
    chk("flush_ready", enq_ready, 0);
    chk("flush_no_issue", dec_insn.valid, 0);
    tick;
    flush = 0; enq_valid = 0; res_ready = 1;
    #1;
    chk("flush_res_valid", res_valid, 0);
    chk("flush_ready_back", enq_ready, 1);
    chk("flush_empty", dec_insn.valid, 0);
    tick;
    chk("flush_enq_lost", res_valid, 0);

    // reset while in SQUASH
    res_ready = 0;
    offer(UOP_BL, 4'd0, 64'd4, 64'h6000, 6'd30, 1'b0, 64'h0);
    tick;
    enq_valid = 0;
    tick;
    chk("r_misp", res_misp, 1);
    chk("r_in_squash", enq_ready, 0);
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("r_res_valid", res_valid, 0);
    chk("r_tag", res_tag, 0);
    chk("r_taken", res_taken, 0);
    chk("r_misp0", res_misp, 0);
    chk("r_next_pc", res_next_pc, 0);
    chk("r_reg_en", reg_pkt.en, 0);
    chk("r_dec_valid", dec_insn.valid, 0);
    chk("r_ready", enq_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
